// File: rtl/sram_rr_arb.sv
// Round-robin arbiter sharing one asynchronous 16-bit SRAM between three masters (SOPC, ADC, test runner).
// Optional: define SRAM_ARB_ADC_PRIO_EN to give master 1 (ADC) absolute priority over 0 and 2.
module sram_rr_arb #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  output logic [ADDR_WIDTH-1:0]       sram_address,
  inout  wire  [DATA_WIDTH-1:0]       sram_data,
  output logic                        sram_ce_n,
  output logic                        sram_oe_n,
  output logic                        sram_we_n,
  output logic [DATA_WIDTH/8-1:0]     sram_be_n,
  input  logic [3*ADDR_WIDTH-1:0]     m_address,
  input  logic [3*(DATA_WIDTH/8)-1:0] m_byteenable,
  input  logic [2:0]                  m_read,
  input  logic [2:0]                  m_write,
  input  logic [3*DATA_WIDTH-1:0]     m_writedata,
  output logic [2:0]                  m_waitrequest,
  output logic [DATA_WIDTH-1:0]       m_readdata,
  output logic [2:0]                  m_readdataready,
  output logic [1:0]                  grant_id,
  output logic                        busy
);

  localparam int BE = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_HOLD
  } state_t;

  state_t                state;
  logic [1:0]            last;
  logic                  is_read_q;
  logic                  drive_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [ADDR_WIDTH-1:0] addr_arr  [0:2];
  logic [BE-1:0]         be_arr    [0:2];
  logic [DATA_WIDTH-1:0] wdata_arr [0:2];
  logic [2:0]            req;
  logic                  accept;
  logic [1:0]            win;
  logic                  win_write;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      addr_arr[i]  = m_address[i*ADDR_WIDTH +: ADDR_WIDTH];
      be_arr[i]    = m_byteenable[i*BE +: BE];
      wdata_arr[i] = m_writedata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign req       = m_read | m_write;
  assign accept    = (state != ST_ACC) && (|req);
  // Simultaneous read and write from one master is executed as a write.
  assign win_write = m_write[win];

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    win = 2'd0;
`ifdef SRAM_ARB_ADC_PRIO_EN
    if (req[1])
      win = 2'd1;
    else if (last == 2'd0)
      win = req[2] ? 2'd2 : 2'd0;
    else
      win = req[0] ? 2'd0 : 2'd2;
`else
    case (last)
      2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
`endif
  end

  always_comb begin
    m_waitrequest = 3'b111;
    if (accept)
      m_waitrequest[win] = 1'b0;
  end

  // Write data stays on the bus through HOLD so it is stable across the we_n rising edge.
  assign sram_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      last            <= 2'd2;
      is_read_q       <= 1'b0;
      drive_q         <= 1'b0;
      wdata_q         <= '0;
      sram_address    <= '0;
      sram_ce_n       <= 1'b1;
      sram_oe_n       <= 1'b1;
      sram_we_n       <= 1'b1;
      sram_be_n       <= '1;
      m_readdata      <= '0;
      m_readdataready <= '0;
      grant_id        <= 2'd0;
      busy            <= 1'b0;
    end else begin
      m_readdataready <= '0;
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            state        <= ST_ACC;
`ifdef SRAM_ARB_ADC_PRIO_EN
            if (win != 2'd1)
              last <= win;
`else
            last         <= win;
`endif
            grant_id     <= win;
            busy         <= 1'b1;
            sram_address <= addr_arr[win];
            sram_be_n    <= ~be_arr[win];
            wdata_q      <= wdata_arr[win];
            is_read_q    <= !win_write;
            drive_q      <= win_write;
            sram_ce_n    <= 1'b0;
            sram_oe_n    <= win_write;
            sram_we_n    <= !win_write;
          end else begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            drive_q   <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= '1;
          end
        end
        ST_ACC: begin
          state     <= ST_HOLD;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          if (is_read_q) begin
            m_readdata      <= sram_data;
            m_readdataready <= 3'b001 << grant_id;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
